// File: rtl/bp_inject_queue_if.sv
// Valid/backpressure stream used on both sides of the injection queue.
// The producer drives d/v; the consumer drives bp.
interface bp_inject_queue_if #(
  parameter int W = 35
);
  logic [W-1:0] d;
  logic         v;
  logic         bp;

  modport master (output d, output v, input bp);
  modport slave  (input d, input v, output bp);
endinterface

// File: rtl/bp_inject_queue.sv
// Injection FIFO between a client output port and a BFT leaf-switch input.
// Absorbs bursts up to DEPTH packets and keeps occupancy and throughput counters.
module bp_inject_queue #(
  parameter int N        = 2,
  parameter int D_W      = 32,
  parameter int A_W      = $clog2(N) + 1,
  parameter int DEPTH    = 4,
  parameter int BP_LEVEL = DEPTH,
  parameter int CNT_W    = 32,
  localparam int PKT_W   = A_W + D_W + 1,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int OCC_W   = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  bp_inject_queue_if.slave     in_if,
  bp_inject_queue_if.master    out_if,
  output logic [OCC_W-1:0]     occupancy,
  output logic [OCC_W-1:0]     high_water,
  output logic [CNT_W-1:0]     pkts_in,
  output logic [CNT_W-1:0]     pkts_out
);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ_nxt;
  logic             push;
  logic             pop;

  // Backpressure and head-valid depend on registered occupancy only.
  assign in_if.bp  = (occupancy >= OCC_W'(BP_LEVEL));
  assign out_if.v  = (occupancy != '0);
  assign out_if.d  = out_if.v ? mem[rd_ptr] : '0;

  assign push = in_if.v & ~in_if.bp;
  assign pop  = out_if.v & ~out_if.bp;

  always_comb begin
    occ_nxt = occupancy;
    case ({push, pop})
      2'b10:   occ_nxt = occupancy + OCC_W'(1);
      2'b01:   occ_nxt = occupancy - OCC_W'(1);
      default: occ_nxt = occupancy;
    endcase
  end

  // Storage array carries no reset; stale entries are masked by out_v.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst)
      mem[wr_ptr] <= in_if.d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      high_water <= '0;
      pkts_in    <= '0;
      pkts_out   <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        pkts_in <= pkts_in + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        pkts_out <= pkts_out + CNT_W'(1);
      end
      occupancy <= occ_nxt;
      if (occ_nxt > high_water)
        high_water <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_bp_inject_queue.sv
// Directed bench for bp_inject_queue: streaming, full/backpressure, BP_LEVEL=2,
// flush, random fill/drain against a FIFO scoreboard, and mid-stream reset.
module tb_bp_inject_queue;
  localparam int PKT_W = 35;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] occupancy, high_water, occ2, hw2;
  logic [31:0] pkts_in, pkts_out, pin2, pout2;

  int n_checks = 0;
  int n_fail   = 0;

  bp_inject_queue_if #(.W(PKT_W)) in_if ();
  bp_inject_queue_if #(.W(PKT_W)) out_if ();
  bp_inject_queue_if #(.W(PKT_W)) in2_if ();
  bp_inject_queue_if #(.W(PKT_W)) out2_if ();

  bp_inject_queue #(.N(2), .D_W(32), .DEPTH(4), .BP_LEVEL(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_if(in_if), .out_if(out_if),
    .occupancy(occupancy), .high_water(high_water), .pkts_in(pkts_in), .pkts_out(pkts_out)
  );

  bp_inject_queue #(.N(2), .D_W(32), .DEPTH(4), .BP_LEVEL(2), .CNT_W(32)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_if(in2_if), .out_if(out2_if),
    .occupancy(occ2), .high_water(hw2), .pkts_in(pin2), .pkts_out(pout2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_bp"}, 64'(in_if.bp), 64'd0);
    chk({tag, "_out_v"}, 64'(out_if.v), 64'd0);
    chk({tag, "_out_d"}, 64'(out_if.d), 64'd0);
    chk({tag, "_occ"}, 64'(occupancy), 64'd0);
    chk({tag, "_hw"}, 64'(high_water), 64'd0);
    chk({tag, "_pin"}, 64'(pkts_in), 64'd0);
    chk({tag, "_pout"}, 64'(pkts_out), 64'd0);
  endtask

  logic [PKT_W-1:0] sb[$];
  int   m_occ;
  logic m_push, m_pop;
  int   seq;

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_if.v = 1'b0; in_if.d = '0; out_if.bp = 1'b0;
    in2_if.v = 1'b0; in2_if.d = '0; out2_if.bp = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_state("reset");

    // Streaming with no switch backpressure: occupancy stays at one.
    in_if.v = 1'b1; in_if.d = 35'd1;
    tick();
    chk("stream_first_v", 64'(out_if.v), 64'd1);
    chk("stream_first_d", 64'(out_if.d), 64'd1);
    for (int i = 2; i <= 6; i++) begin
      in_if.d = 35'(i);
      tick();
      chk("stream_d", 64'(out_if.d), 64'(i));
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    in_if.v = 1'b0;
    tick();
    chk("stream_drain_v", 64'(out_if.v), 64'd0);
    chk("stream_pin", 64'(pkts_in), 64'd6);
    chk("stream_pout", 64'(pkts_out), 64'd6);

    // Fill under switch backpressure, then release with a held fifth packet.
    out_if.bp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_if.v = 1'b1; in_if.d = 35'(32'hA + i);
      tick();
    end
    chk("full_in_bp", 64'(in_if.bp), 64'd1);
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_hw", 64'(high_water), 64'd4);
    chk("full_head", 64'(out_if.d), 64'hA);
    in_if.d = 35'hE;
    tick();
    chk("held_occ", 64'(occupancy), 64'd4);
    chk("held_pin", 64'(pkts_in), 64'd10);
    out_if.bp = 1'b0;
    tick();
    chk("nopass_occ", 64'(occupancy), 64'd3);
    chk("nopass_pin", 64'(pkts_in), 64'd10);
    chk("nopass_head", 64'(out_if.d), 64'hB);
    tick();
    chk("accept_occ", 64'(occupancy), 64'd3);
    chk("accept_pin", 64'(pkts_in), 64'd11);
    chk("accept_head", 64'(out_if.d), 64'hC);
    in_if.v = 1'b0;
    tick();
    chk("drain_d", 64'(out_if.d), 64'hD);
    tick();
    chk("drain_e", 64'(out_if.d), 64'hE);
    chk("drain_occ", 64'(occupancy), 64'd1);
    tick();
    chk("drain_empty", 64'(out_if.v), 64'd0);
    chk("drain_pout", 64'(pkts_out), 64'd11);

    // BP_LEVEL=2 instance: at most two entries ever stored.
    in2_if.v = 1'b1; in2_if.d = 35'h21;
    tick();
    chk("bp2_occ1", 64'(occ2), 64'd1);
    chk("bp2_bp1", 64'(in2_if.bp), 64'd0);
    in2_if.d = 35'h22;
    tick();
    chk("bp2_occ2", 64'(occ2), 64'd2);
    chk("bp2_bp2", 64'(in2_if.bp), 64'd1);
    in2_if.d = 35'h23;
    tick(); tick();
    chk("bp2_occ_hold", 64'(occ2), 64'd2);
    chk("bp2_hw", 64'(hw2), 64'd2);
    chk("bp2_pin", 64'(pin2), 64'd2);
    in2_if.v = 1'b0;

    // Flush with three queued and a packet offered in the flush cycle.
    rst = 1'b1; tick(); rst = 1'b0;
    out_if.bp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_if.v = 1'b1; in_if.d = 35'(32'h11 + i);
      tick();
    end
    chk("preflush_occ", 64'(occupancy), 64'd3);
    in_if.d = 35'h14; flush = 1'b1;
    tick();
    flush = 1'b0; in_if.v = 1'b0;
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_out_v", 64'(out_if.v), 64'd0);
    chk("flush_in_bp", 64'(in_if.bp), 64'd0);
    chk("flush_pin", 64'(pkts_in), 64'd3);
    chk("flush_pout", 64'(pkts_out), 64'd0);
    chk("flush_hw", 64'(high_water), 64'd3);

    // Random fill/drain against a FIFO scoreboard, from a fresh reset.
    rst = 1'b1; tick(); rst = 1'b0;
    m_occ = 0; seq = 1;
    in_if.v = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!in_if.v) begin
        in_if.v = ($urandom_range(3, 0) != 0);
        in_if.d = 35'(seq);
      end
      out_if.bp = ($urandom_range(2, 0) == 0);
      m_push = in_if.v && (m_occ < 4);
      m_pop  = (m_occ != 0) && !out_if.bp;
      chk("rnd_in_bp", 64'(in_if.bp), 64'(m_occ >= 4));
      if (m_pop) chk("rnd_order", 64'(out_if.d), 64'(sb[0]));
      tick();
      if (m_pop) void'(sb.pop_front());
      if (m_push) begin
        sb.push_back(in_if.d);
        seq++;
        in_if.v = 1'b0;
      end
      m_occ = sb.size();
      chk("rnd_occ", 64'(occupancy), 64'(m_occ));
      chk("rnd_balance", 64'(pkts_in - pkts_out), 64'(occupancy));
    end
    in_if.v = 1'b0; out_if.bp = 1'b0;
    for (int k = 0; k < 8 && m_occ != 0; k++) begin
      chk("rnd_drain", 64'(out_if.d), 64'(sb[0]));
      tick();
      void'(sb.pop_front());
      m_occ = sb.size();
    end
    chk("rnd_empty", 64'(out_if.v), 64'd0);
    chk("rnd_pin", 64'(pkts_in), 64'(seq - 1));
    chk("rnd_pout", 64'(pkts_out), 64'(seq - 1));

    // Reset mid-stream discards the in-flight packet.
    out_if.bp = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_if.v = 1'b1; in_if.d = 35'(32'h40 + i);
      tick();
    end
    rst = 1'b1; in_if.d = 35'h42;
    tick();
    rst = 1'b0; in_if.v = 1'b0;
    chk_reset_state("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/bp_inject_queue.md
Name: bp_inject_queue

Overview:
- Injection buffer between a traffic client's output port (c_o / c_o_v / c_o_bp) and the leaf-switch input port of the BFT network.
- Decouples client injection from network backpressure. It absorbs bursts up to DEPTH packets and presents one packet per cycle to the switch.
- Keeps occupancy and throughput counters for the simulation/performance flow.
- Packets are opaque: payload is {flag bit, dest address, data}, width A_W+D_W+1.

Parameters:
- N, 2, total number of clients; sets A_W.
- D_W, 32, data width.
- A_W, $clog2(N)+1, address width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- BP_LEVEL, DEPTH, occupancy at or above which in_bp is asserted; 1..DEPTH.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous queue clear; counters unaffected.
- in_d  in  A_W+D_W+1  packet from client.
- in_v  in  1  packet valid from client.
- in_bp  out  1  backpressure to client.
- out_d  out  A_W+D_W+1  packet to switch (head entry).
- out_v  out  1  head valid.
- out_bp  in  1  backpressure from switch.
- occupancy  out  $clog2(DEPTH)+1  current entry count.
- high_water  out  $clog2(DEPTH)+1  maximum occupancy since reset.
- pkts_in  out  CNT_W  accepted packets.
- pkts_out  out  CNT_W  delivered packets.

Behaviour:
- Handshake, both sides: a transfer happens at a rising edge where valid=1 and bp=0.
  - Producer holds data and valid stable while bp=1.
  - in_d is don't-care when in_v=0.
- push = in_v & ~in_bp.
- pop = out_v & ~out_bp.
- in_bp = (occupancy >= BP_LEVEL). It is a function of registered state only; no combinational path from out_bp or in_v.
  - With BP_LEVEL=DEPTH there is no pass-through when full: a simultaneous pop does not allow a push that cycle.
- out_v = (occupancy != 0). out_d = mem[rd_ptr].
- Storage: circular array, wr_ptr/rd_ptr $clog2(DEPTH) bits, wrap modulo DEPTH. occupancy is a separate register.
- Latency: a packet pushed at edge k is visible on out_d/out_v after edge k. Minimum in-to-out is 1 cycle; there is no bypass.
- Per edge:
  - push only: write at wr_ptr, wr_ptr+1, occupancy+1.
  - pop only: rd_ptr+1, occupancy-1.
  - push and pop: both pointers advance, occupancy unchanged.
  - Order is strictly FIFO.
- pkts_in increments on push, pkts_out on pop. Both wrap at 2^CNT_W.
- high_water <= max(high_water, next occupancy) every edge.
- flush (rst=0):
  - pointers and occupancy go to 0; out_v=0 and in_bp=0 on the next cycle.
  - push/pop in the flush cycle are ignored and not counted.
  - high_water and packet counters are retained.
- rst, with priority over flush:
  - in_bp=0, out_v=0, occupancy=0, high_water=0, pkts_in=0, pkts_out=0, pointers=0.
  - out_d=0; memory contents are not reset.
  - A packet mid-handshake at reset is discarded.
  - The client must re-present it; the client's own reset clears its c_o_v.
- Invariants:
  - occupancy <= DEPTH at all times.
  - pkts_in - pkts_out == occupancy, modulo 2^CNT_W, between flushes.

Test Plan:
- Reset, then in_v=1 streaming with out_bp=0 and DEPTH=4 -> out_v rises 1 cycle after first push; packets emerge in order at one per cycle; occupancy stays 1; pkts_in==pkts_out after drain.
- out_bp=1 held while pushing 0xA,0xB,0xC,0xD -> in_bp=1 after 4th push; 5th packet is held by the client; occupancy=4, high_water=4. Release out_bp -> A,B,C,D,then 5th delivered in order.
- Full queue with out_bp=0 and in_v=1 simultaneously -> pop occurs; push is blocked that cycle and accepted the next cycle; occupancy 4->3->3.
- BP_LEVEL=2, DEPTH=4, out_bp=1 -> in_bp asserts at occupancy 2; at most 2 entries are ever stored; high_water=2.
- 3 packets queued, pulse flush with in_v=1 -> occupancy=0 and out_v=0 next cycle; pkts_in unchanged by the flush-cycle packet; high_water=3 retained.
- Repeated fill/drain over 10 wraps of the pointers with random out_bp -> scoreboard order matches; no loss or duplication; pkts_in-pkts_out==occupancy every cycle. Assert rst mid-stream -> all outputs at reset values next cycle.
